tx_msg_table: RTL

//  Endpoint message table, directly upstream of the TX packet FSM. Software programs a
//  per-slot packet start address in the TX cache, then writes a send mask. The table

---
 rtl/tx_msg_table.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tx_msg_table.sv
// tx_msg_table: endpoint message table in front of the TX packet FSM.
// Software programs per-slot start addresses, then writes a send mask; the
// table round-robin arbitrates pending slots, launches one trigger_send pulse
// per packet and retires the slot on tx_done.
// Optional feature macro: TX_MSG_TABLE_IRQ_EN (IRQ_MASK register + done_irq).

// Per-slot state: pending / in-flight flags plus the start-address register.
module tx_msg_slot (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        set_pend,
  input  logic        grant,
  input  logic        retire,
  input  logic        addr_we,
  input  logic [31:0] wdata,
  output logic        pend,
  output logic        infl,
  output logic [31:0] start_addr
);
  // FREE -> PENDING -> IN_FLIGHT -> FREE; the parent only raises set_pend and
  // addr_we on a FREE slot, and grant only on a PENDING one.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pend       <= 1'b0;
      infl       <= 1'b0;
      start_addr <= '0;
    end else begin
      if (set_pend) pend <= 1'b1;
      if (grant) begin
        pend <= 1'b0;
        infl <= 1'b1;
      end
      if (retire)  infl       <= 1'b0;
      if (addr_we) start_addr <= wdata;
    end
  end
endmodule

module tx_msg_table #(
  parameter int          NUM_MSGS      = 4,
  parameter logic [31:0] TX_SEND_ADDR  = 32'h1004,
  parameter logic [31:0] PKT_ADDR_BASE = 32'h1010
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wen,
  input  logic                     ren,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     request_stall,
  output logic [NUM_MSGS-1:0]      trigger_send,
  output logic [NUM_MSGS*32-1:0]   pkt_start_addr,
  input  logic                     tx_idle,
`ifdef TX_MSG_TABLE_IRQ_EN
  output logic                     done_irq,
`endif
  input  logic                     tx_done
);
  localparam int PW = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;

  logic [NUM_MSGS-1:0]       pend, infl, busy, free, mask;
  logic [NUM_MSGS-1:0]       set_pend, slot_sel, slot_we, grant_oh, retire, w1c, done_q;
  logic [NUM_MSGS-1:0][31:0] slot_addr;
  logic                      send_wr, done_wr, grant_en, err_q, err_set, err_clr;
  logic [PW-1:0]             rr_ptr, rr_next;
  logic                      unused_ren;

  assign unused_ren    = ren;        // reads are side-effect free
  assign request_stall = 1'b0;

  assign send_wr  = wen && (addr == TX_SEND_ADDR);
  assign done_wr  = wen && (addr == TX_SEND_ADDR + 32'd4);
  assign mask     = wdata[NUM_MSGS-1:0];
  assign busy     = pend | infl;
  assign free     = ~busy;
  // A slot retiring this cycle still counts as busy, so a same-cycle send to it is rejected.
  assign set_pend = send_wr ? (mask & free) : '0;
  assign slot_we  = wen ? (slot_sel & free) : '0;
  assign err_set  = (send_wr && |(mask & busy)) || (wen && |(slot_sel & busy));
  assign err_clr  = send_wr && wdata[31];
  assign w1c      = done_wr ? mask : '0;
  assign retire   = tx_done ? infl : '0;
  // Requiring nothing in flight also blocks a grant in the tx_done cycle.
  assign grant_en = tx_idle && !(|infl) && (|pend);

  assign trigger_send   = grant_oh;
  assign pkt_start_addr = slot_addr;

  for (genvar i = 0; i < NUM_MSGS; i++) begin : g_slot
    assign slot_sel[i] = (addr == PKT_ADDR_BASE + 32'(4 * i));
    tx_msg_slot u_slot (
      .clk        (clk),
      .n_rst      (n_rst),
      .set_pend   (set_pend[i]),
      .grant      (grant_oh[i]),
      .retire     (retire[i]),
      .addr_we    (slot_we[i]),
      .wdata      (wdata),
      .pend       (pend[i]),
      .infl       (infl[i]),
      .start_addr (slot_addr[i])
    );
  end

  // Round-robin pick: first pending slot at or above rr_ptr, wrapping.
  always_comb begin
    logic found;
    grant_oh = '0;
    rr_next  = rr_ptr;
    found    = 1'b0;
    for (int k = 0; k < NUM_MSGS; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_MSGS) idx = idx - NUM_MSGS;
      if (!found && grant_en && pend[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        rr_next       = (idx == NUM_MSGS - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Shared state: rr pointer, sticky done mask (set beats W1C), sticky err.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rr_ptr <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (|grant_oh) rr_ptr <= rr_next;
      done_q <= (done_q & ~w1c) | retire;
      err_q  <= (err_q & ~err_clr) | err_set;
    end
  end

`ifdef TX_MSG_TABLE_IRQ_EN
  logic [31:0] irq_mask;
  // IRQ mask register and registered completion interrupt.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      irq_mask <= '0;
      done_irq <= 1'b0;
    end else begin
      if (wen && (addr == TX_SEND_ADDR + 32'd8)) irq_mask <= wdata;
      done_irq <= |(done_q & irq_mask[NUM_MSGS-1:0]);
    end
  end
`endif

  // Combinational read mux; unmapped addresses return 0.
  always_comb begin
    rdata = '0;
    if (addr == TX_SEND_ADDR) begin
      rdata[NUM_MSGS-1:0]          = busy;
      rdata[2*NUM_MSGS-1:NUM_MSGS] = infl;
      rdata[31]                    = err_q;
    end else if (addr == TX_SEND_ADDR + 32'd4) begin
      rdata[NUM_MSGS-1:0] = done_q;
`ifdef TX_MSG_TABLE_IRQ_EN
    end else if (addr == TX_SEND_ADDR + 32'd8) begin
      rdata = irq_mask;
`endif
    end else begin
      for (int i = 0; i < NUM_MSGS; i++)
        if (slot_sel[i]) rdata = slot_addr[i];
    end
  end
endmodule
